multicycle_control: RTL and testbench

Multi-cycle MIPS control unit: a Moore FSM that sequences fetch, decode, execute, memory and write-back over several cycles for R-type, addi, lw, sw, beq and j. It replaces the single-cycle opcode decoder in the multi-cycle datapath. It drives the shared-memory, IR, PC and register-file enables. It adds:
- a memory ready handshake
- a global stall
- illegal-opcode trapping
- a retired-instruction counter

---
 rtl/multicycle_control_if.sv | 50 +++++
 rtl/multicycle_control.sv | 220 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_if
// Brief    : Control-unit bundle: opcode/handshake inputs, datapath strobes out.
// Revision : 1.0
// ============================================================================
interface multicycle_control_if #(
    parameter int OP_W  = 6,
    parameter int CNT_W = 32
);
    logic [OP_W-1:0]  op_i;
    logic             mem_ready_i;
    logic             stall_i;
    logic             pc_write_o;
    logic             pc_write_cond_o;
    logic             ir_write_o;
    logic             reg_write_o;
    logic             mem_read_o;
    logic             mem_write_o;
    logic             i_or_d_o;
    logic             mem_to_reg_o;
    logic             reg_dst_o;
    logic             alu_src_a_o;
    logic [1:0]       alu_src_b_o;
    logic [1:0]       alu_op_o;
    logic [1:0]       pc_source_o;
    logic             trap_o;
    logic             instr_done_o;
    logic [CNT_W-1:0] instr_count_o;
    logic [3:0]       state_o;

    // Control unit side
    modport master (
        input  op_i, mem_ready_i, stall_i,
        output pc_write_o, pc_write_cond_o, ir_write_o, reg_write_o,
               mem_read_o, mem_write_o, i_or_d_o, mem_to_reg_o, reg_dst_o,
               alu_src_a_o, alu_src_b_o, alu_op_o, pc_source_o,
               trap_o, instr_done_o, instr_count_o, state_o
    );

    // Datapath / environment side
    modport slave (
        output op_i, mem_ready_i, stall_i,
        input  pc_write_o, pc_write_cond_o, ir_write_o, reg_write_o,
               mem_read_o, mem_write_o, i_or_d_o, mem_to_reg_o, reg_dst_o,
               alu_src_a_o, alu_src_b_o, alu_op_o, pc_source_o,
               trap_o, instr_done_o, instr_count_o, state_o
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Brief    : Multi-cycle MIPS control FSM with memory handshake, stall,
//            illegal-opcode trap and retired-instruction counter.
// Revision : 1.0
// ============================================================================
module multicycle_control #(
    parameter int OP_W            = 6,
    parameter int CNT_W           = 32,
    parameter int MEM_HANDSHAKE   = 1,
    parameter int TRAP_ON_ILLEGAL = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EX   = 4'd11,
        S_ADDI_WB   = 4'd12,
        S_TRAP      = 4'd13
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       trap;
        logic       retire;
        logic       retire_rdy;
    } ctrl_t;

    localparam logic [OP_W-1:0] c_op_rtype = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] c_op_addi  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] c_op_lw    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] c_op_sw    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] c_op_beq   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] c_op_j     = OP_W'(6'b000010);

    state_t           r_state;
    ctrl_t            r_ctrl;
    logic [OP_W-1:0]  r_op;
    logic [CNT_W-1:0] r_count;
    logic             r_armed;

    state_t w_next;
    logic   w_ready;
    logic   w_run;
    logic   w_fetch;
    logic   w_legal;
    logic   w_retire;

    function automatic logic f_legal(input logic [OP_W-1:0] op);
        return (op == c_op_rtype) || (op == c_op_addi) || (op == c_op_lw) ||
               (op == c_op_sw)    || (op == c_op_beq)  || (op == c_op_j);
    endfunction

    function automatic state_t f_next(input state_t s, input logic [OP_W-1:0] op,
                                      input logic [OP_W-1:0] op_q, input logic rdy,
                                      input logic armed);
        state_t n;
        n = s;
        case (s)
            S_IDLE:      if (armed) n = S_FETCH;
            S_FETCH:     if (rdy) n = S_DECODE;
            S_DECODE: begin
                if (op == c_op_lw || op == c_op_sw) n = S_MEM_ADDR;
                else if (op == c_op_rtype)          n = S_EXECUTE;
                else if (op == c_op_addi)           n = S_ADDI_EX;
                else if (op == c_op_beq)            n = S_BRANCH;
                else if (op == c_op_j)              n = S_JUMP;
                else n = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;
            end
            S_MEM_ADDR:  n = (op_q == c_op_lw) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (rdy) n = S_MEM_WB;
            S_MEM_WRITE: if (rdy) n = S_FETCH;
            S_EXECUTE:   n = S_ALU_WB;
            S_ADDI_EX:   n = S_ADDI_WB;
            S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_ADDI_WB: n = S_FETCH;
            S_TRAP:      n = S_TRAP;
            default:     n = S_IDLE;
        endcase
        return n;
    endfunction

    // Moore decode of a state; registered against the next state so the
    // outputs line up with r_state without a decode path after the flops.
    function automatic ctrl_t f_decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_DECODE:    c.alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.retire     = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_write  = 1'b1;
                c.i_or_d     = 1'b1;
                c.retire_rdy = 1'b1;
            end
            S_EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_ALU_WB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
                c.retire        = 1'b1;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
                c.retire    = 1'b1;
            end
            S_ADDI_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_ADDI_WB: begin
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
            end
            S_TRAP:      c.trap = 1'b1;
            default:     c = '0;
        endcase
        return c;
    endfunction

    assign w_ready  = (MEM_HANDSHAKE == 0) || bus.mem_ready_i;
    assign w_run    = !bus.stall_i;
    assign w_fetch  = (r_state == S_FETCH);
    assign w_legal  = f_legal(bus.op_i);
    assign w_next   = f_next(r_state, bus.op_i, r_op, w_ready, r_armed);
    assign w_retire = w_run && (r_ctrl.retire || (r_ctrl.retire_rdy && w_ready) ||
                      ((r_state == S_DECODE) && !w_legal && (TRAP_ON_ILLEGAL == 0)));

    // r_armed spends one cycle after reset release so FETCH starts on the 2nd edge
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_ctrl  <= '0;
            r_op    <= '0;
            r_count <= '0;
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (w_run) begin
                r_state <= w_next;
                r_ctrl  <= f_decode(w_next);
                if (r_state == S_DECODE) r_op <= bus.op_i;
                if (w_retire) r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign bus.pc_write_o      = w_run && r_ctrl.pc_write && (!w_fetch || w_ready);
    assign bus.ir_write_o      = w_run && r_ctrl.ir_write && w_ready;
    assign bus.pc_write_cond_o = w_run && r_ctrl.pc_write_cond;
    assign bus.reg_write_o     = w_run && r_ctrl.reg_write;
    assign bus.mem_read_o      = w_run && r_ctrl.mem_read;
    assign bus.mem_write_o     = w_run && r_ctrl.mem_write;
    assign bus.i_or_d_o        = r_ctrl.i_or_d;
    assign bus.mem_to_reg_o    = r_ctrl.mem_to_reg;
    assign bus.reg_dst_o       = r_ctrl.reg_dst;
    assign bus.alu_src_a_o     = r_ctrl.alu_src_a;
    assign bus.alu_src_b_o     = r_ctrl.alu_src_b;
    assign bus.alu_op_o        = r_ctrl.alu_op;
    assign bus.pc_source_o     = r_ctrl.pc_source;
    assign bus.trap_o          = r_ctrl.trap;
    assign bus.instr_done_o    = w_retire;
    assign bus.instr_count_o   = r_count;
    assign bus.state_o         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Two control units (32-bit counter/trap, 4-bit counter/no-trap)
//            driven in lockstep against an instruction-level step model.
// Revision : 1.0
// ============================================================================
module tb_multicycle_control;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef struct packed {
        logic       pcw, pcwc, irw, rw, mr, mw, iord, m2r, rdst, srca;
        logic [1:0] srcb, aluop, pcsrc;
        logic       trap;
    } ctrl_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_control_if #(.OP_W(6), .CNT_W(32)) bus_a ();
    multicycle_control_if #(.OP_W(6), .CNT_W(4))  bus_b ();

    multicycle_control #(.OP_W(6), .CNT_W(32), .MEM_HANDSHAKE(1), .TRAP_ON_ILLEGAL(1))
        dut_a (.clk_i(clk), .rst_i(rst_n), .bus(bus_a));
    multicycle_control #(.OP_W(6), .CNT_W(4), .MEM_HANDSHAKE(1), .TRAP_ON_ILLEGAL(0))
        dut_b (.clk_i(clk), .rst_i(rst_n), .bus(bus_b));

    ctrl_t w_ctrl_a, w_ctrl_b;
    assign w_ctrl_a = {bus_a.pc_write_o, bus_a.pc_write_cond_o, bus_a.ir_write_o, bus_a.reg_write_o,
                       bus_a.mem_read_o, bus_a.mem_write_o, bus_a.i_or_d_o, bus_a.mem_to_reg_o,
                       bus_a.reg_dst_o, bus_a.alu_src_a_o, bus_a.alu_src_b_o, bus_a.alu_op_o,
                       bus_a.pc_source_o, bus_a.trap_o};
    assign w_ctrl_b = {bus_b.pc_write_o, bus_b.pc_write_cond_o, bus_b.ir_write_o, bus_b.reg_write_o,
                       bus_b.mem_read_o, bus_b.mem_write_o, bus_b.i_or_d_o, bus_b.mem_to_reg_o,
                       bus_b.reg_dst_o, bus_b.alu_src_a_o, bus_b.alu_src_b_o, bus_b.alu_op_o,
                       bus_b.pc_source_o, bus_b.trap_o};

    int n_checks = 0;
    int n_errors = 0;

    // Model: current expected state plus the remaining state list of the instruction
    int         exp_state;
    int         exp_cnt;
    int         steps[$];
    int         op_mode;
    int         seq_idx;
    logic [5:0] cur_op;
    logic [5:0] seq_ops [6] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic ctrl_t exp_ctrl(input int s, input logic rdy, input logic stl);
        ctrl_t c;
        c = '0;
        case (s)
            1:  begin c.mr = 1'b1; c.srcb = 2'b01; c.irw = rdy; c.pcw = rdy; end
            2:  c.srcb = 2'b11;
            3:  begin c.srca = 1'b1; c.srcb = 2'b10; end
            4:  begin c.mr = 1'b1; c.iord = 1'b1; end
            5:  begin c.m2r = 1'b1; c.rw = 1'b1; end
            6:  begin c.mw = 1'b1; c.iord = 1'b1; end
            7:  begin c.srca = 1'b1; c.aluop = 2'b10; end
            8:  begin c.rdst = 1'b1; c.rw = 1'b1; end
            9:  begin c.srca = 1'b1; c.aluop = 2'b01; c.pcwc = 1'b1; c.pcsrc = 2'b01; end
            10: begin c.pcw = 1'b1; c.pcsrc = 2'b10; end
            11: begin c.srca = 1'b1; c.srcb = 2'b10; end
            12: c.rw = 1'b1;
            13: c.trap = 1'b1;
            default: c = '0;
        endcase
        if (stl) begin
            c.pcw = 1'b0; c.pcwc = 1'b0; c.irw = 1'b0; c.rw = 1'b0; c.mr = 1'b0; c.mw = 1'b0;
        end
        return c;
    endfunction

    task automatic new_instr();
        case (op_mode)
            0:       begin cur_op = seq_ops[seq_idx % 6]; seq_idx++; end
            1:       cur_op = seq_ops[$urandom_range(5)];
            default: cur_op = OP_R;
        endcase
        case (cur_op)
            OP_R:    steps = '{2, 7, 8};
            OP_ADDI: steps = '{2, 11, 12};
            OP_LW:   steps = '{2, 3, 4, 5};
            OP_SW:   steps = '{2, 3, 6};
            OP_BEQ:  steps = '{2, 9};
            default: steps = '{2, 10};
        endcase
    endtask

    task automatic drive(input logic rdy, input logic stl, input logic [5:0] op);
        bus_a.mem_ready_i = rdy; bus_b.mem_ready_i = rdy;
        bus_a.stall_i     = stl; bus_b.stall_i     = stl;
        bus_a.op_i        = op;  bus_b.op_i        = op;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_state_a"}, bus_a.state_o, 0);
        check({tag, "_state_b"}, bus_b.state_o, 0);
        check({tag, "_ctrl_a"}, w_ctrl_a, 0);
        check({tag, "_ctrl_b"}, w_ctrl_b, 0);
        check({tag, "_done_a"}, bus_a.instr_done_o, 0);
        check({tag, "_done_b"}, bus_b.instr_done_o, 0);
        check({tag, "_count_a"}, bus_a.instr_count_o, 0);
        check({tag, "_count_b"}, bus_b.instr_count_o, 0);
    endtask

    // Leaves the bench at posedge+1 just after the first edge following release
    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_state = 0;
        exp_cnt   = 0;
        steps.delete();
    endtask

    // Called at posedge+1; checks at negedge, advances the model after the next edge
    task automatic run_cycle(input logic rdy, input logic stl);
        logic  ret;
        ctrl_t e;
        if (exp_state == 0) stl = 1'b0;
        drive(rdy, stl, (exp_state == 2) ? cur_op : 6'($urandom));
        ret = !stl && ((exp_state inside {5, 8, 9, 10, 12}) || (exp_state == 6 && rdy));
        e   = exp_ctrl(exp_state, rdy, stl);
        @(negedge clk);
        check("state_a", bus_a.state_o, 64'(exp_state));
        check("state_b", bus_b.state_o, 64'(exp_state));
        check("ctrl_a", w_ctrl_a, e);
        check("ctrl_b", w_ctrl_b, e);
        check("done_a", bus_a.instr_done_o, ret);
        check("done_b", bus_b.instr_done_o, ret);
        check("count_a", bus_a.instr_count_o, 64'(exp_cnt));
        check("count_b", bus_b.instr_count_o, 64'(exp_cnt % 16));
        @(posedge clk); #1;
        if (!stl) begin
            if (exp_state == 0) begin
                exp_state = 1;
                new_instr();
            end else if (!(exp_state inside {1, 4, 6}) || rdy) begin
                if (steps.size() == 0) begin
                    exp_state = 1;
                    new_instr();
                end else begin
                    exp_state = steps.pop_front();
                end
            end
            if (ret) exp_cnt++;
        end
    endtask

    initial begin
        logic rdy, stl;
        op_mode = 0;
        seq_idx = 0;
        rst_n   = 1'b0;
        drive(1'b1, 1'b0, 6'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        release_reset();

        // Zero-wait directed instruction mix
        for (int i = 0; i < 60; i++) run_cycle(1'b1, 1'b0);

        // Random memory waits and stalls over random legal instructions
        op_mode = 1;
        for (int i = 0; i < 400; i++) run_cycle($urandom_range(3) != 0, $urandom_range(7) == 0);

        // Abort an R-type in EXECUTE with an asynchronous reset
        op_mode = 2;
        for (int i = 0; i < 60 && exp_state != 7; i++) run_cycle(1'b1, 1'b0);
        check("reach_exec", bus_a.state_o, 7);
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        release_reset();

        // Illegal opcode: dut_a traps, dut_b retires it as a NOP
        drive(1'b1, 1'b0, 6'd0);
        @(negedge clk); check("ill_idle", bus_a.state_o, 0);
        @(posedge clk); #1;
        @(negedge clk); check("ill_fetch_a", bus_a.state_o, 1); check("ill_fetch_b", bus_b.state_o, 1);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 6'b111111);
        @(negedge clk);
        check("ill_dec_a", bus_a.state_o, 2);
        check("ill_done_a", bus_a.instr_done_o, 0);
        check("ill_done_b", bus_b.instr_done_o, 1);
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            rdy = 1'($urandom);
            stl = 1'($urandom);
            drive(rdy, stl, 6'($urandom));
            @(negedge clk);
            check("trap_state", bus_a.state_o, 13);
            check("trap_ctrl", w_ctrl_a, exp_ctrl(13, rdy, stl));
            check("trap_done", bus_a.instr_done_o, 0);
            if (i == 0) begin
                check("nop_state_b", bus_b.state_o, 1);
                check("nop_count_b", bus_b.instr_count_o, 1);
                check("trap_count_a", bus_a.instr_count_o, 0);
            end
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1 check_zero("trap_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
